// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//   Iterative restoring divider (WIDTH = 8 only). A request is accepted on
//   START in IDLE or DONE. The divider then runs one shift-subtract step per
//   clock and registers quotient/remainder after the eighth step. BUSYWAIT
//   stalls the CPU for the whole time a division is in flight.
//
//   Ports
//     CLK        rising-edge clock
//     RESET      asynchronous, active-low reset
//     START      request, sampled in IDLE/DONE
//     DIVIDEND   operand A, sampled on the accepting edge
//     DIVISOR    operand B, sampled on the accepting edge
//     QUOTIENT   registered quotient (8'hFF on divide by zero)
//     REMAINDER  registered remainder (DIVIDEND on divide by zero)
//     VALID      high for the single cycle spent in DONE
//     DIVZERO    registered; the last loaded result came from DIVISOR == 0
//     BUSYWAIT   combinational stall to the PC/register file
//
//   Optional feature macro: DIV_SIGNED_EN
//     When defined, operands are two's complement. Magnitudes are divided,
//     the quotient is negated if the signs differ, and the remainder takes
//     the sign of the dividend. Latency is unchanged.
// ---------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] DIVIDEND,
    input  logic [WIDTH-1:0] DIVISOR,
    output logic [WIDTH-1:0] QUOTIENT,
    output logic [WIDTH-1:0] REMAINDER,
    output logic             VALID,
    output logic             DIVZERO,
    output logic             BUSYWAIT
);

    localparam int               CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] rem;      // restored remainder, always < divisor
    logic [WIDTH-1:0] dq;       // dividend shifting out / quotient shifting in
    logic [WIDTH-1:0] dvsr;
    logic [CW-1:0]    count;

    // One restoring step. The shifted remainder needs the ninth bit because
    // rem can be up to 254 before the shift.
    logic [WIDTH:0]   rem_sh;
    logic             fits;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] dq_nxt;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] r_res;

    always_comb begin
        rem_sh  = {rem, dq[WIDTH-1]};
        fits    = (rem_sh >= {1'b0, dvsr});
        rem_nxt = fits ? WIDTH'(rem_sh - {1'b0, dvsr}) : rem_sh[WIDTH-1:0];
        dq_nxt  = {dq[WIDTH-2:0], fits};
    end

`ifdef DIV_SIGNED_EN
    logic q_neg;
    logic r_neg;

    always_comb begin
        a_mag = DIVIDEND[WIDTH-1] ? (~DIVIDEND + WIDTH'(1)) : DIVIDEND;
        b_mag = DIVISOR[WIDTH-1]  ? (~DIVISOR  + WIDTH'(1)) : DIVISOR;
        // -128 / -1 falls out naturally: 128 / 1 = 8'h80, signs equal.
        q_res = q_neg ? (~dq_nxt  + WIDTH'(1)) : dq_nxt;
        r_res = r_neg ? (~rem_nxt + WIDTH'(1)) : rem_nxt;
    end
`else
    always_comb begin
        a_mag = DIVIDEND;
        b_mag = DIVISOR;
        q_res = dq_nxt;
        r_res = rem_nxt;
    end
`endif

    assign BUSYWAIT = (START && (state == IDLE || state == DONE))
                    || (state == DIVIDE);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            rem       <= '0;
            dq        <= '0;
            dvsr      <= '0;
            count     <= '0;
            QUOTIENT  <= '0;
            REMAINDER <= '0;
            VALID     <= 1'b0;
            DIVZERO   <= 1'b0;
`ifdef DIV_SIGNED_EN
            q_neg     <= 1'b0;
            r_neg     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (START) begin
                        rem   <= '0;
                        count <= '0;
                        dq    <= a_mag;
                        dvsr  <= b_mag;
`ifdef DIV_SIGNED_EN
                        q_neg <= DIVIDEND[WIDTH-1] ^ DIVISOR[WIDTH-1];
                        r_neg <= DIVIDEND[WIDTH-1];
`endif
                        if (DIVISOR == '0) begin
                            QUOTIENT  <= '1;
                            REMAINDER <= DIVIDEND;
                            DIVZERO   <= 1'b1;
                            VALID     <= 1'b1;
                            state     <= DONE;
                        end else begin
                            VALID <= 1'b0;
                            state <= DIVIDE;
                        end
                    end else begin
                        VALID <= 1'b0;
                        state <= IDLE;
                    end
                end

                DIVIDE: begin
                    rem   <= rem_nxt;
                    dq    <= dq_nxt;
                    count <= count + CW'(1);
                    if (count == LAST) begin
                        QUOTIENT  <= q_res;
                        REMAINDER <= r_res;
                        DIVZERO   <= 1'b0;
                        VALID     <= 1'b1;
                        state     <= DONE;
                    end
                end

                default: begin
                    VALID <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
